// File: rtl/ps2_pkg.sv
// Shared PS/2 scancode constants, ASCII control codes and frame FSM encoding.
package ps2_pkg;

  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;
  localparam logic [7:0] PS2_CAPS   = 8'h58;
  localparam logic [7:0] PS2_ENTER  = 8'h5A;

  localparam logic [6:0] ASCII_BS  = 7'h08;
  localparam logic [6:0] ASCII_TAB = 7'h09;
  localparam logic [6:0] ASCII_CR  = 7'h0D;
  localparam logic [6:0] ASCII_ESC = 7'h1B;
  localparam logic [6:0] ASCII_SP  = 7'h20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } frame_state_e;

endpackage

// File: rtl/ps2_scancode_lut.sv
// Scancode set 2 to 7-bit ASCII, US layout; upper selects the shifted glyph.
module ps2_scancode_lut
  import ps2_pkg::*;
(
  input  logic [7:0] code,
  input  logic       upper,
  output logic [6:0] ascii
);

  logic [6:0] lo;
  logic [6:0] hi;

  always_comb begin
    lo = '0;
    hi = '0;
    case (code)
      8'h1C: begin lo = 7'h61; hi = 7'h41; end
      8'h32: begin lo = 7'h62; hi = 7'h42; end
      8'h21: begin lo = 7'h63; hi = 7'h43; end
      8'h23: begin lo = 7'h64; hi = 7'h44; end
      8'h24: begin lo = 7'h65; hi = 7'h45; end
      8'h2B: begin lo = 7'h66; hi = 7'h46; end
      8'h34: begin lo = 7'h67; hi = 7'h47; end
      8'h33: begin lo = 7'h68; hi = 7'h48; end
      8'h43: begin lo = 7'h69; hi = 7'h49; end
      8'h3B: begin lo = 7'h6A; hi = 7'h4A; end
      8'h42: begin lo = 7'h6B; hi = 7'h4B; end
      8'h4B: begin lo = 7'h6C; hi = 7'h4C; end
      8'h3A: begin lo = 7'h6D; hi = 7'h4D; end
      8'h31: begin lo = 7'h6E; hi = 7'h4E; end
      8'h44: begin lo = 7'h6F; hi = 7'h4F; end
      8'h4D: begin lo = 7'h70; hi = 7'h50; end
      8'h15: begin lo = 7'h71; hi = 7'h51; end
      8'h2D: begin lo = 7'h72; hi = 7'h52; end
      8'h1B: begin lo = 7'h73; hi = 7'h53; end
      8'h2C: begin lo = 7'h74; hi = 7'h54; end
      8'h3C: begin lo = 7'h75; hi = 7'h55; end
      8'h2A: begin lo = 7'h76; hi = 7'h56; end
      8'h1D: begin lo = 7'h77; hi = 7'h57; end
      8'h22: begin lo = 7'h78; hi = 7'h58; end
      8'h35: begin lo = 7'h79; hi = 7'h59; end
      8'h1A: begin lo = 7'h7A; hi = 7'h5A; end
      8'h16: begin lo = 7'h31; hi = 7'h21; end
      8'h1E: begin lo = 7'h32; hi = 7'h40; end
      8'h26: begin lo = 7'h33; hi = 7'h23; end
      8'h25: begin lo = 7'h34; hi = 7'h24; end
      8'h2E: begin lo = 7'h35; hi = 7'h25; end
      8'h36: begin lo = 7'h36; hi = 7'h5E; end
      8'h3D: begin lo = 7'h37; hi = 7'h26; end
      8'h3E: begin lo = 7'h38; hi = 7'h2A; end
      8'h46: begin lo = 7'h39; hi = 7'h28; end
      8'h45: begin lo = 7'h30; hi = 7'h29; end
      8'h0E: begin lo = 7'h60; hi = 7'h7E; end
      8'h4E: begin lo = 7'h2D; hi = 7'h5F; end
      8'h55: begin lo = 7'h3D; hi = 7'h2B; end
      8'h54: begin lo = 7'h5B; hi = 7'h7B; end
      8'h5B: begin lo = 7'h5D; hi = 7'h7D; end
      8'h5D: begin lo = 7'h5C; hi = 7'h7C; end
      8'h4C: begin lo = 7'h3B; hi = 7'h3A; end
      8'h52: begin lo = 7'h27; hi = 7'h22; end
      8'h41: begin lo = 7'h2C; hi = 7'h3C; end
      8'h49: begin lo = 7'h2E; hi = 7'h3E; end
      8'h4A: begin lo = 7'h2F; hi = 7'h3F; end
      8'h29: begin lo = ASCII_SP;  hi = ASCII_SP;  end
      8'h5A: begin lo = ASCII_CR;  hi = ASCII_CR;  end
      8'h66: begin lo = ASCII_BS;  hi = ASCII_BS;  end
      8'h0D: begin lo = ASCII_TAB; hi = ASCII_TAB; end
      8'h76: begin lo = ASCII_ESC; hi = ASCII_ESC; end
      default: begin lo = '0; hi = '0; end
    endcase
    ascii = upper ? hi : lo;
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver with set-2 scancode to ASCII decode.
// Optional caps-lock handling is enabled by defining PS2_CAPS_LOCK_EN.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] out,
  output logic       frame_err
);

  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] clk_s;
  logic [SYNC_STAGES-1:0] data_s;
  logic                   fall;
  logic                   bit_in;

  frame_state_e state, state_next;
  logic [3:0]      cnt;
  logic [10:0]     sr;
  logic [WD_W-1:0] wd;
  logic            timeout;
  logic            frame_ok;
  logic            byte_ok;
  logic            err_next;
  logic [7:0]      code;

  logic       brk;
  logic       ext;
  logic       shift;
  logic [6:0] lut_ascii;
  logic [6:0] ascii;

  // Index 0 is the newest sample; edge detect compares the two oldest stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s  <= '1;
      data_s <= '1;
    end else begin
      clk_s  <= {clk_s[SYNC_STAGES-2:0], ps2_clk};
      data_s <= {data_s[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign fall   = clk_s[SYNC_STAGES-1] & ~clk_s[SYNC_STAGES-2];
  assign bit_in = data_s[SYNC_STAGES-1];

  // sr[0]=start, sr[8:1]=data, sr[9]=parity, sr[10]=stop once 11 bits are in.
  assign code     = sr[8:1];
  assign frame_ok = ~sr[0] & sr[10] & (^sr[9:1]);
  assign timeout  = (state == SHIFT) && !fall && (wd == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    byte_ok    = 1'b0;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (fall) state_next = SHIFT;
      end
      SHIFT: begin
        if (fall && cnt == 4'd10) begin
          state_next = CHECK;
        end else if (timeout) begin
          state_next = IDLE;
          err_next   = 1'b1;
        end
      end
      CHECK: begin
        state_next = IDLE;
        byte_ok    = frame_ok;
        err_next   = ~frame_ok;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
      wd  <= '0;
    end else begin
      if (fall && state != CHECK) sr <= {bit_in, sr[10:1]};
      if (state == SHIFT && !fall) wd <= wd + 1'b1;
      else                         wd <= '0;
      case (state)
        IDLE:    cnt <= fall ? 4'd1 : 4'd0;
        SHIFT: begin
          if (fall)         cnt <= cnt + 4'd1;
          else if (timeout) cnt <= '0;
        end
        default: cnt <= '0;
      endcase
    end
  end

  ps2_scancode_lut u_lut (
    .code  (code),
    .upper (shift),
    .ascii (lut_ascii)
  );

`ifdef PS2_CAPS_LOCK_EN
  logic caps;
  logic is_letter;

  // Caps only flips letters; the LUT already applied shift, so XOR the case bit.
  always_comb begin
    is_letter = ((lut_ascii >= 7'h41) && (lut_ascii <= 7'h5A)) ||
                ((lut_ascii >= 7'h61) && (lut_ascii <= 7'h7A));
    ascii     = (caps && is_letter) ? (lut_ascii ^ 7'h20) : lut_ascii;
  end
`else
  always_comb begin
    ascii = lut_ascii;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      frame_err <= 1'b0;
      brk       <= 1'b0;
      ext       <= 1'b0;
      shift     <= 1'b0;
`ifdef PS2_CAPS_LOCK_EN
      caps      <= 1'b0;
`endif
    end else begin
      out       <= '0;
      frame_err <= err_next;
      if (state == CHECK && !frame_ok) begin
        brk <= 1'b0;
        ext <= 1'b0;
      end
      if (byte_ok) begin
        if (code == PS2_EXT) begin
          ext <= 1'b1;
        end else if (code == PS2_BRK) begin
          brk <= 1'b1;
        end else if (brk) begin
          if (code == PS2_LSHIFT || code == PS2_RSHIFT) shift <= 1'b0;
          brk <= 1'b0;
          ext <= 1'b0;
        end else begin
          ext <= 1'b0;
          if (code == PS2_LSHIFT || code == PS2_RSHIFT) begin
            shift <= 1'b1;
`ifdef PS2_CAPS_LOCK_EN
          end else if (code == PS2_CAPS) begin
            caps <= ~caps;
`endif
          end else if (ext) begin
            if (code == PS2_ENTER) out <= {1'b1, ASCII_CR};
          end else if (ascii != '0) begin
            out <= {1'b1, ascii};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx: frames are bit-banged on the PS/2 pins.
module tb_ps2_keyboard_rx;

  localparam int unsigned TO = 3000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] out;
  logic       frame_err;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  logic [7:0] exp_q[$];
  logic prev_strobe = 1'b0;
  logic prev_err = 1'b0;

  ps2_keyboard_rx #(
    .TIMEOUT_CYCLES (TO),
    .SYNC_STAGES    (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .out       (out),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Output monitor: pops the scoreboard on each strobe, checks pulse widths.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst_n) begin
      prev_strobe = 1'b0;
      prev_err    = 1'b0;
    end else begin
      if (prev_strobe) begin
        checks++;
        if (out !== 8'h00) begin
          errors++;
          $display("FAIL strobe_width out=%02h required 00", out);
        end
      end
      if (prev_err) begin
        checks++;
        if (frame_err !== 1'b0) begin
          errors++;
          $display("FAIL err_width frame_err=%b required 0", frame_err);
        end
      end
      if (out[7] === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe out=%02h required none", out);
        end else begin
          e = exp_q.pop_front();
          if (out !== e) begin
            errors++;
            $display("FAIL strobe_value out=%02h required %02h", out, e);
          end
        end
      end
      if (frame_err === 1'b1) err_seen++;
      prev_strobe = (out[7] === 1'b1);
      prev_err    = (frame_err === 1'b1);
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] code, input bit flip_par, input int nbits);
    logic [10:0] b;
    b = {1'b1, (~^code) ^ flip_par, code, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = b[i];
      wait_clks(10);
      ps2_clk = 1'b0;
      wait_clks(20);
      ps2_clk = 1'b1;
      wait_clks(10);
    end
    ps2_data = 1'b1;
    if (nbits == 11) wait_clks(30);
  endtask

  task automatic send_ok(input logic [7:0] code);
    send_frame(code, 1'b0, 11);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    wait_clks(4);
    #1;
    checks++;
    if (out !== 8'h00) begin
      errors++;
      $display("FAIL reset_out out=%02h required 00", out);
    end
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err frame_err=%b required 0", frame_err);
    end
    rst_n = 1'b1;
    wait_clks(4);
  endtask

  task automatic test_single_frame;
    int e0;
    e0 = err_seen;
    exp_q.push_back(8'hE1);
    send_ok(8'h1C);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_pending left=%0d required 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (err_seen != e0) begin
      errors++;
      $display("FAIL single_err pulses=%0d required 0", err_seen - e0);
    end
  endtask

  task automatic test_shift_release;
    exp_q.push_back(8'hC1);
    exp_q.push_back(8'hE1);
    send_ok(8'h12); send_ok(8'h1C); send_ok(8'hF0); send_ok(8'h1C);
    send_ok(8'hF0); send_ok(8'h12); send_ok(8'h1C);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL shift_pending left=%0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_parity_error;
    int e0;
    e0 = err_seen;
    send_frame(8'h1C, 1'b1, 11);
    checks++;
    if (err_seen != e0 + 1) begin
      errors++;
      $display("FAIL parity_err pulses=%0d required 1", err_seen - e0);
    end
    exp_q.push_back(8'hE2);
    send_ok(8'h32);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL parity_recover left=%0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_timeout;
    int e0;
    e0 = err_seen;
    send_frame(8'h45, 1'b0, 5);
    wait_clks(TO + 50);
    checks++;
    if (err_seen != e0 + 1) begin
      errors++;
      $display("FAIL timeout_err pulses=%0d required 1", err_seen - e0);
    end
    exp_q.push_back(8'hB0);
    send_ok(8'h45);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL timeout_recover left=%0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_frame;
    send_frame(8'hF0, 1'b0, 6);
    rst_n = 1'b0;
    wait_clks(5);
    #1;
    checks++;
    if (out !== 8'h00 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state out=%02h err=%b required 00/0", out, frame_err);
    end
    rst_n = 1'b1;
    wait_clks(5);
    exp_q.push_back(8'hE1);
    send_ok(8'h1C);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_recover left=%0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_extended_and_controls;
    exp_q.push_back(8'h8D);
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'h88);
    exp_q.push_back(8'h9B);
    exp_q.push_back(8'h89);
    exp_q.push_back(8'hA1);
    send_ok(8'hE0); send_ok(8'h5A);
    send_ok(8'hE0); send_ok(8'h75);
    send_ok(8'h29); send_ok(8'h66); send_ok(8'h76); send_ok(8'h0D);
    send_ok(8'h59); send_ok(8'h16); send_ok(8'hF0); send_ok(8'h59);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL ext_ctrl_pending left=%0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'hE1);
      send_frame(8'h1C, 1'b0, 11);
    end
    exp_q.push_back(8'hB9);
    send_ok(8'h46);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL typematic_pending left=%0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_caps_lock;
`ifdef PS2_CAPS_LOCK_EN
    exp_q.push_back(8'hC1);
    exp_q.push_back(8'hE1);
    exp_q.push_back(8'hB1);
    send_ok(8'h58); send_ok(8'h1C);
    send_ok(8'h12); send_ok(8'h1C);
    send_ok(8'hF0); send_ok(8'h12);
    send_ok(8'hF0); send_ok(8'h58);
    send_ok(8'h16);
`else
    exp_q.push_back(8'hE1);
    send_ok(8'h58); send_ok(8'h1C);
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL caps_pending left=%0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #20ms;
    $display("FAIL global_timeout sim time exceeded");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    test_reset;
    test_single_frame;
    test_shift_release;
    test_parity_error;
    test_timeout;
    test_reset_mid_frame;
    test_extended_and_controls;
    test_back_to_back;
    test_caps_lock;
    wait_clks(20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
